// File: rtl/hack_bitwise_pkg.sv
// Shared types for the bitwise pipe: op encoding and the per-bit reference op.
// Optional flags build: HACK_BITWISE_PIPE_FLAGS_EN.
package hack_bitwise_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOT_A = 3'd0;
    localparam op_t OP_AND   = 3'd1;
    localparam op_t OP_OR    = 3'd2;
    localparam op_t OP_XOR   = 3'd3;
    localparam op_t OP_NAND  = 3'd4;
    localparam op_t OP_NOR   = 3'd5;
    localparam op_t OP_PASS  = 3'd6;
    localparam op_t OP_NOT_B = 3'd7;

    // Defined per bit so any operand width can reuse it without truncation.
    function automatic logic op_bit(op_t op, logic a, logic b);
        logic r;
        r = 1'b0;
        unique case (op)
            OP_NOT_A: r = ~a;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_PASS:  r = a;
            OP_NOT_B: r = ~b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hack_bitwise_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO with occupancy output.
// Head reads as zero while empty so the output matches its reset value.
module hack_bitwise_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hack_bitwise_pipe.sv
// Selectable bitwise op on WIDTH-bit operands, buffered in a DEPTH-entry FIFO.
// HACK_BITWISE_PIPE_FLAGS_EN adds per-beat zero/negative flags (out_zr, out_ng).
module hack_bitwise_pipe
    import hack_bitwise_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef HACK_BITWISE_PIPE_FLAGS_EN
    output logic                     out_zr,
    output logic                     out_ng,
`endif
    output logic [$clog2(DEPTH):0]   level
);

`ifdef HACK_BITWISE_PIPE_FLAGS_EN
    localparam int FW = WIDTH + 2;
`else
    localparam int FW = WIDTH;
`endif

    logic [WIDTH-1:0] result;
    logic [FW-1:0]    wdata;
    logic [FW-1:0]    rdata;
    logic             full;
    logic             empty;

    always_comb begin
        result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            result[i] = op_bit(op_t'(in_op), in_a[i], in_b[i]);
        end
    end

`ifdef HACK_BITWISE_PIPE_FLAGS_EN
    // Flags ride in the top two bits of each entry.
    assign wdata    = {result[WIDTH-1], ~|result, result};
    assign out_data = rdata[WIDTH-1:0];
    assign out_zr   = rdata[WIDTH];
    assign out_ng   = rdata[WIDTH+1];
`else
    assign wdata    = result;
    assign out_data = rdata;
`endif

    assign in_ready  = !full;
    assign out_valid = !empty;

    hack_bitwise_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule
